// File: rtl/booth_mul_sequencer.sv
// Radix-2 Booth sequencer for the MUL path: one shared-adder pass per iteration,
// producing a 2*WIDTH-bit signed product on hi/lo after exactly WIDTH iterations.
module booth_mul_sequencer #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_cin,
  input  logic [WIDTH-1:0] add_s,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {StIdle, StIter, StDone} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q, q_q, m_q;
  logic             qm1_q;
  logic [CNT_W-1:0] count_q;
  logic [WIDTH-1:0] hi_q, lo_q;

  logic             ovf, sgn, last_iter;
  logic [WIDTH-1:0] a_next, q_next;

  // Adder operands are forced to zero outside ITER so the shared adder stays quiet.
  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    if (state_q == StIter) begin
      add_a = a_q;
      case ({q_q[0], qm1_q})
        2'b01: add_b = m_q;
        2'b10: begin
          add_b   = ~m_q;
          add_cin = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // The adder drops the carry-out; recover the true sign before the arithmetic shift.
  always_comb begin
    ovf       = (add_a[WIDTH-1] == add_b[WIDTH-1]) && (add_s[WIDTH-1] != add_a[WIDTH-1]);
    sgn       = add_s[WIDTH-1] ^ ovf;
    a_next    = {sgn, add_s[WIDTH-1:1]};
    q_next    = {add_s[0], q_q[WIDTH-1:1]};
    last_iter = (count_q == CNT_W'(WIDTH - 1));
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= StIdle;
      a_q     <= '0;
      q_q     <= '0;
      m_q     <= '0;
      qm1_q   <= 1'b0;
      count_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            a_q     <= '0;
            q_q     <= multiplier;
            m_q     <= multiplicand;
            qm1_q   <= 1'b0;
            count_q <= '0;
            state_q <= StIter;
          end
        end
        StIter: begin
          a_q     <= a_next;
          q_q     <= q_next;
          qm1_q   <= q_q[0];
          count_q <= count_q + 1'b1;
          if (last_iter) begin
            // Result is captured here so hi/lo are already valid while done is high.
            hi_q    <= a_next;
            lo_q    <= q_next;
            state_q <= StDone;
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy = (state_q == StIter);
  assign done = (state_q == StDone);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
